// File: rtl/pe_array_drain.sv
// pe_array_drain: output-side collector for the weight-stationary systolic PE array.
// Deskews the per-column partial sums leaving the bottom of the array, accumulates
// the aligned vectors over K tile passes into a local buffer, and after the last
// pass drains the buffer through a valid/ready stream.
//
// Optional build macro DRAIN_RELU_EN: when defined, each output column is clamped
// to zero if negative at the output register (the buffer keeps raw values).
module pe_array_drain #(
    parameter int data_width         = 19,
    parameter int a_tile_row_size    = 14,
    parameter int w_tile_column_size = 2,
    parameter int acc_width          = 42,
    parameter int max_vec            = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          tile_start,
    input  logic [$clog2(max_vec):0]                      tile_len,
    input  logic                                          first_k,
    input  logic                                          last_k,
    input  logic [2*data_width*w_tile_column_size-1:0]    array_sum,
    output logic                                          busy,
    output logic                                          overrun,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [acc_width*w_tile_column_size-1:0]       out_data,
    output logic                                          out_last
);

    localparam int W        = w_tile_column_size;
    localparam int SUM_W    = 2 * data_width;
    localparam int AW       = $clog2(max_vec);
    localparam int LW       = AW + 1;
    // Cycles spent in WAIT so that the first CAPTURE cycle lands on the aligned vector 0.
    localparam int WAIT_CYC = a_tile_row_size + W - 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        DRAIN
    } state_t;

    state_t                     state;
    logic [LW-1:0]              n_q;
    logic                       first_q;
    logic                       last_q;
    logic [15:0]                wait_cnt;
    logic [AW-1:0]              cap_idx;
    logic [LW-1:0]              rd_ptr;

    logic signed [SUM_W-1:0]    col_raw_p0 [W];
    logic signed [SUM_W-1:0]    col_al_p1  [W];
    logic signed [acc_width-1:0] acc_mem [max_vec][W];
    logic [acc_width*W-1:0]     drain_word;

    // Sign-extend one column sum to accumulator width.
    function automatic logic signed [acc_width-1:0] sext(input logic signed [SUM_W-1:0] s);
        return acc_width'(s);
    endfunction

    // Output-stage activation: clamp negatives when the ReLU build is selected.
    function automatic logic signed [acc_width-1:0] relu(input logic signed [acc_width-1:0] v);
`ifdef DRAIN_RELU_EN
        return v[acc_width-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // ---- stage p0 -> p1: per-column deskew ----
    // Column j leaves the array j cycles after column 0 for the same vector, so it is
    // held back W-1-j cycles; the last column needs no delay.
    for (genvar j = 0; j < W; j++) begin : g_col
        localparam int D = W - 1 - j;

        assign col_raw_p0[j] = array_sum[j*SUM_W +: SUM_W];

        if (D == 0) begin : g_nodly
            assign col_al_p1[j] = col_raw_p0[j];
        end else begin : g_dly
            logic signed [SUM_W-1:0] dly_p1 [D];

            // Shift register that holds this column back until the last column catches up.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) dly_p1[k] <= '0;
                end else begin
                    dly_p1[0] <= col_raw_p0[j];
                    for (int k = 1; k < D; k++) dly_p1[k] <= dly_p1[k-1];
                end
            end

            assign col_al_p1[j] = dly_p1[D-1];
        end
    end

    // ---- stage p1 -> buffer: accumulate aligned vector ----
    // Buffer write: overwrite on the first K pass, otherwise add with two's-complement wrap.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            for (int j = 0; j < W; j++) begin
                acc_mem[cap_idx][j] <= first_q ? sext(col_al_p1[j])
                                               : acc_mem[cap_idx][j] + sext(col_al_p1[j]);
            end
        end
    end

    // ---- buffer -> output register: drain read ----
    // Read the current drain entry and apply the optional activation on the way out.
    always_comb begin
        drain_word = '0;
        for (int j = 0; j < W; j++) begin
            drain_word[j*acc_width +: acc_width] = relu(acc_mem[rd_ptr[AW-1:0]][j]);
        end
    end

    // Control FSM with registered status and output stream registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            n_q       <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            wait_cnt  <= '0;
            cap_idx   <= '0;
            rd_ptr    <= '0;
        end else begin
            // A start request outside IDLE is dropped but remembered until reset.
            if (tile_start && (state != IDLE)) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (tile_start && (tile_len != '0)) begin
                        n_q      <= tile_len;
                        first_q  <= first_k;
                        last_q   <= last_k;
                        wait_cnt <= 16'(WAIT_CYC - 1);
                        cap_idx  <= '0;
                        rd_ptr   <= '0;
                        busy     <= 1'b1;
                        state    <= (WAIT_CYC == 0) ? CAPTURE : WAIT;
                    end
                end

                WAIT: begin
                    if (wait_cnt == 16'd0) state <= CAPTURE;
                    else                   wait_cnt <= wait_cnt - 16'd1;
                end

                CAPTURE: begin
                    if ({1'b0, cap_idx} == (n_q - LW'(1))) begin
                        if (last_q) begin
                            state <= DRAIN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cap_idx <= cap_idx + AW'(1);
                    end
                end

                DRAIN: begin
                    if (out_valid && out_ready && out_last) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else if ((!out_valid || out_ready) && (rd_ptr != n_q)) begin
                        // Output register is free or being emptied this cycle: load next entry.
                        out_valid <= 1'b1;
                        out_data  <= drain_word;
                        out_last  <= (rd_ptr == (n_q - LW'(1)));
                        rd_ptr    <= rd_ptr + LW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
